// File: rtl/camera_sched_pkg.sv
// Shared types and defaults for the camera frame scheduler.
package camera_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    ARM        = 3'd2,
    TRIG       = 3'd3,
    WAIT_END   = 3'd4,
    DONE       = 3'd5
  } sched_state_t;

  localparam logic [31:0] CAM_DRAM_ADDR_BASE = 32'h8000_0000;
  localparam logic [31:0] CAM_FRAME_BYTES    = 32'h0010_0000;

  // Slot index width; never narrower than one bit.
  function automatic int unsigned buf_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buf_ring_tracker.sv
// DRAM slot ring bookkeeping: write/read pointers, fill level, full flag.
// A release with nothing filled and no frame landing that cycle is flagged as underflow.
module buf_ring_tracker import camera_sched_pkg::*; #(
  parameter int unsigned NUM_BUFFERS = 4,
  localparam int unsigned IW = buf_idx_width(NUM_BUFFERS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  output logic [IW-1:0] wr_ptr,
  output logic [IW:0]   fill,
  output logic          full,
  output logic          underflow
);

  logic [IW-1:0] rd_ptr;
  logic          pop_ok;

  // A frame landing in the same cycle makes an otherwise-empty release legal.
  assign pop_ok    = pop && ((fill != '0) || push);
  assign underflow = pop && !pop_ok;
  assign full      = (fill == (IW+1)'(NUM_BUFFERS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop_ok)      fill <= fill + 1'b1;
      else if (pop_ok && !push) fill <= fill - 1'b1;
    end
  end

endmodule

// File: rtl/camera_frame_scheduler.sv
// Camera Link acquisition sequencer: periodic triggers, DRAM slot ring, completion reporting.
// Optional WAIT_END watchdog with a timeout pulse is built when CAMERA_FRAME_TIMEOUT_EN is defined.
module camera_frame_scheduler import camera_sched_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DRAM_ADDR_BASE = ADDR_WIDTH'(CAM_DRAM_ADDR_BASE),
  parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES    = ADDR_WIDTH'(CAM_FRAME_BYTES),
  parameter int unsigned NUM_BUFFERS = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TRIG_WIDTH  = 16,
`ifdef CAMERA_FRAME_TIMEOUT_EN
  parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = CNT_WIDTH'(32'd50_000_000),
`endif
  localparam int unsigned IW = buf_idx_width(NUM_BUFFERS)
) (
  input  logic                  clk_pixel,
  input  logic                  clk_pixel_resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  num_frames,
  input  logic [CNT_WIDTH-1:0]  trig_period,
  input  logic                  clink_X_ready,
  input  logic                  image_end,
  input  logic                  buf_release,
  output logic                  trigger,
  output logic [ADDR_WIDTH-1:0] frame_base_addr,
  output logic                  frame_done,
  output logic [IW-1:0]         frame_idx,
  output logic [CNT_WIDTH-1:0]  frames_captured,
  output logic                  buf_full,
  output logic                  busy,
`ifdef CAMERA_FRAME_TIMEOUT_EN
  output logic                  timeout,
`endif
  output logic                  error
);

  localparam int unsigned TCW = $clog2(TRIG_WIDTH + 1);

  sched_state_t         state, state_n;
  logic [CNT_WIDTH-1:0] num_frames_q, trig_period_q, period_cnt;
  logic [TCW-1:0]       trig_cnt;
  logic [IW-1:0]        wr_ptr, done_idx_q;
  logic [IW:0]          fill;
  logic                 stop_pending, stop_req, start_ok, period_ok, fire;
  logic                 trig_last, frame_push, last_frame, spurious_end;
  logic                 ring_full, ring_underflow, wd_expire;

  assign stop_req     = stop | stop_pending;
  assign start_ok     = (state == IDLE) && start && !stop;
  // Compare against the count one cycle ahead so rising edges land exactly trig_period apart.
  assign period_ok    = ({1'b0, period_cnt} + (CNT_WIDTH+1)'(1)) >= {1'b0, trig_period_q};
  assign fire         = (state == ARM) && !stop_req && period_ok && !ring_full && clink_X_ready;
  assign trig_last    = (trig_cnt == TCW'(TRIG_WIDTH - 1));
  assign frame_push   = (state == DONE);
  assign last_frame   = (num_frames_q != '0) && ((frames_captured + CNT_WIDTH'(1)) == num_frames_q);
  assign spurious_end = image_end && (state != WAIT_END);

`ifdef CAMERA_FRAME_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] wd_cnt;

  assign wd_expire = (state == WAIT_END) && !image_end && (wd_cnt == TIMEOUT_CYCLES - CNT_WIDTH'(1));
  assign timeout   = wd_expire;

  always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn)      wd_cnt <= '0;
    else if (state == WAIT_END) wd_cnt <= wd_cnt + CNT_WIDTH'(1);
    else                        wd_cnt <= '0;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start_ok) state_n = WAIT_READY;
      WAIT_READY: if (stop_req) state_n = IDLE;
                  else if (clink_X_ready) state_n = ARM;
      ARM:        if (stop_req) state_n = IDLE;
                  else if (fire) state_n = TRIG;
      TRIG:       if (trig_last) state_n = WAIT_END;
      WAIT_END:   if (image_end) state_n = DONE;
                  else if (wd_expire) state_n = stop_req ? IDLE : ARM;
      DONE:       state_n = (stop_req || last_frame) ? IDLE : ARM;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn) begin
      state           <= IDLE;
      stop_pending    <= 1'b0;
      num_frames_q    <= '0;
      trig_period_q   <= '0;
      period_cnt      <= '0;
      trig_cnt        <= '0;
      frame_base_addr <= DRAM_ADDR_BASE;
      frames_captured <= '0;
      done_idx_q      <= '0;
      error           <= 1'b0;
    end else begin
      state        <= state_n;
      stop_pending <= (state_n == IDLE) ? 1'b0 : (stop_pending | stop);
      if (start_ok) begin
        num_frames_q  <= num_frames;
        trig_period_q <= trig_period;
      end
      trig_cnt <= ((state == TRIG) && !trig_last) ? trig_cnt + TCW'(1) : '0;
      // Saturated count at start lets the first trigger go out immediately.
      if (start_ok)                period_cnt <= '1;
      else if (fire)               period_cnt <= '0;
      else if (period_cnt != '1)   period_cnt <= period_cnt + CNT_WIDTH'(1);
      if (fire) frame_base_addr <= DRAM_ADDR_BASE + ADDR_WIDTH'(wr_ptr) * FRAME_BYTES;
      if (start_ok)        frames_captured <= '0;
      else if (frame_push) frames_captured <= frames_captured + CNT_WIDTH'(1);
      if (frame_push) done_idx_q <= wr_ptr;
      if (spurious_end || ring_underflow || wd_expire) error <= 1'b1;
      else if (start_ok)                               error <= 1'b0;
    end
  end

  buf_ring_tracker #(.NUM_BUFFERS(NUM_BUFFERS)) u_ring (
    .clk       (clk_pixel),
    .rst_n     (clk_pixel_resetn),
    .push      (frame_push),
    .pop       (buf_release),
    .wr_ptr    (wr_ptr),
    .fill      (fill),
    .full      (ring_full),
    .underflow (ring_underflow)
  );

  assign trigger    = (state == TRIG);
  assign frame_done = frame_push;
  assign frame_idx  = frame_push ? wr_ptr : done_idx_q;
  assign buf_full   = ring_full;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_camera_frame_scheduler.sv
// Bench for camera_frame_scheduler: vector table of acquisition runs plus hand-written corner sequences.
module tb_camera_frame_scheduler;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] FB   = 32'h0010_0000;

  typedef struct {
    int nf;       // num_frames
    int tp;       // trig_period
    int dly;      // trigger rise to image_end, cycles
    int spacing;  // expected rise-to-rise spacing (0 = single frame)
    int frames;   // expected frames captured
  } vec_t;

  logic        clk_pixel = 1'b0;
  logic        clk_pixel_resetn = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clink_X_ready = 1'b1;
  logic [31:0] num_frames = '0, trig_period = '0;
  logic        cam_end = 1'b0, spur_end = 1'b0, cam_rel = 1'b0, man_rel = 1'b0;
  logic        image_end, buf_release;
  logic        trigger, frame_done, buf_full, busy, error;
  logic [31:0] frame_base_addr, frames_captured;
  logic [1:0]  frame_idx;
`ifdef CAMERA_FRAME_TIMEOUT_EN
  logic        timeout;
`endif

  assign image_end   = cam_end | spur_end;
  assign buf_release = cam_rel | man_rel;

`ifdef CAMERA_FRAME_TIMEOUT_EN
  camera_frame_scheduler #(.TIMEOUT_CYCLES(32'd100)) dut (
`else
  camera_frame_scheduler dut (
`endif
    .clk_pixel(clk_pixel), .clk_pixel_resetn(clk_pixel_resetn),
    .start(start), .stop(stop), .num_frames(num_frames), .trig_period(trig_period),
    .clink_X_ready(clink_X_ready), .image_end(image_end), .buf_release(buf_release),
    .trigger(trigger), .frame_base_addr(frame_base_addr), .frame_done(frame_done),
    .frame_idx(frame_idx), .frames_captured(frames_captured), .buf_full(buf_full),
    .busy(busy),
`ifdef CAMERA_FRAME_TIMEOUT_EN
    .timeout(timeout),
`endif
    .error(error)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Camera/DMA model and scoreboard
  int   n_rises = 0, n_dones = 0, rise_cyc = 0, prev_rise = -1, exp_spacing = 0;
  int   cam_delay = 40, end_at = 0, mon_wr = 0;
  bit   cam_en = 1'b1, auto_rel = 1'b1, pend = 1'b0;
  logic trig_prev = 1'b0;
  int   sb[$];

  initial forever begin
    @(negedge clk_pixel);
    cam_end = 1'b0;
    cam_rel = 1'b0;
    if (!clk_pixel_resetn) begin
      trig_prev = 1'b0; pend = 1'b0; mon_wr = 0; prev_rise = -1; sb.delete();
    end else begin
      if (trigger && !trig_prev) begin
        logic [31:0] exp_addr;
        exp_addr = BASE + 32'(mon_wr) * FB;
        n_rises++;
        check("trig_addr", frame_base_addr, exp_addr);
        if (exp_spacing != 0 && prev_rise >= 0) check("trig_spacing", cyc - prev_rise, exp_spacing);
        prev_rise = cyc;
        rise_cyc  = cyc;
        if (cam_en) begin pend = 1'b1; end_at = cyc + cam_delay; end
      end
      if (!trigger && trig_prev) check("trig_width", cyc - rise_cyc, 16);
      trig_prev = trigger;
      if (pend && cyc == end_at) begin
        cam_end = 1'b1;
        pend    = 1'b0;
        sb.push_back(mon_wr);
        mon_wr  = (mon_wr + 1) % 4;
      end
      if (frame_done) begin
        n_dones++;
        if (sb.size() == 0) check("sb_underrun", 1, 0);
        else check("frame_idx", frame_idx, sb.pop_front());
        if (auto_rel) cam_rel = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pixel);
  endtask

  task automatic do_reset();
    clk_pixel_resetn = 1'b0;
    tick(3);
    clk_pixel_resetn = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start(input int nf, input int tp);
    num_frames = 32'(nf); trig_period = 32'(tp); prev_rise = -1;
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_rel();
    man_rel = 1'b1; tick(1); man_rel = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(1); k++; end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_rises(input string name, input int target, input int budget);
    int k = 0;
    while (n_rises < target && k < budget) begin tick(1); k++; end
    check({name, "_rise_seen"}, n_rises >= target, 1);
  endtask

  task automatic wait_dones(input string name, input int target, input int budget);
    int k = 0;
    while (n_dones < target && k < budget) begin tick(1); k++; end
    check({name, "_done_seen"}, n_dones >= target, 1);
  endtask

  initial begin
    #800_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   r0, d0, c_ready;
    vecs[0] = '{nf: 1, tp: 0,    dly: 500, spacing: 0,    frames: 1};
    vecs[1] = '{nf: 3, tp: 1000, dly: 200, spacing: 1000, frames: 3};
    vecs[2] = '{nf: 3, tp: 0,    dly: 40,  spacing: 43,   frames: 3};
    vecs[3] = '{nf: 4, tp: 100,  dly: 30,  spacing: 100,  frames: 4};
    vecs[4] = '{nf: 2, tp: 50,   dly: 60,  spacing: 63,   frames: 2};

    do_reset();
    check("rst_trigger", trigger, 0);
    check("rst_addr", frame_base_addr, BASE);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_frames_captured", frames_captured, 0);
    check("rst_buf_full", buf_full, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);

    for (int i = 0; i < 5; i++) begin
      cam_en = 1'b1; auto_rel = 1'b1;
      cam_delay = vecs[i].dly; exp_spacing = vecs[i].spacing;
      r0 = n_rises; d0 = n_dones;
      pulse_start(vecs[i].nf, vecs[i].tp);
      wait_idle("vec", 20000);
      check("vec_frames_captured", frames_captured, vecs[i].frames);
      check("vec_triggers", n_rises - r0, vecs[i].frames);
      check("vec_dones", n_dones - d0, vecs[i].frames);
      check("vec_error", error, 0);
      check("vec_sb_empty", sb.size(), 0);
    end

    // Ring wrap: nothing released until four slots fill
    do_reset();
    auto_rel = 1'b0; cam_delay = 40; exp_spacing = 0;
    r0 = n_rises; d0 = n_dones;
    pulse_start(6, 0);
    wait_dones("wrap4", d0 + 4, 2000);
    tick(100);
    check("wrap_buf_full", buf_full, 1);
    check("wrap_stalled_rises", n_rises - r0, 4);
    check("wrap_busy", busy, 1);
    pulse_rel();
    wait_rises("wrap5", r0 + 5, 100);
    check("wrap_addr5", frame_base_addr, BASE);
    auto_rel = 1'b1;
    wait_idle("wrap", 2000);
    check("wrap_frames", frames_captured, 6);
    check("wrap_error", error, 0);
    do_reset();

    // Stop during WAIT_END in continuous mode
    cam_delay = 300; r0 = n_rises; d0 = n_dones;
    pulse_start(0, 0);
    wait_rises("stop", r0 + 2, 2000);
    tick(100);
    stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("stop", 2000);
    check("stop_frames", frames_captured, 2);
    check("stop_dones", n_dones - d0, 2);
    tick(400);
    check("stop_no_more_trig", n_rises - r0, 2);
    check("stop_busy", busy, 0);

    // Ready gating
    clink_X_ready = 1'b0; cam_delay = 40; r0 = n_rises;
    pulse_start(1, 0);
    tick(50);
    check("ready_no_trig", n_rises - r0, 0);
    check("ready_busy", busy, 1);
    clink_X_ready = 1'b1; c_ready = cyc;
    wait_rises("ready", r0 + 1, 100);
    check("ready_first_trig_cycle", rise_cyc, c_ready + 2);
    wait_idle("ready", 500);

    // Spurious image_end while armed
    pulse_start(2, 2000);
    d0 = n_dones;
    wait_dones("spur", d0 + 1, 500);
    tick(50);
    check("spur_pre_error", error, 0);
    spur_end = 1'b1; tick(1); spur_end = 1'b0; tick(2);
    check("spur_error", error, 1);
    check("spur_frames_unchanged", frames_captured, 1);
    check("spur_dones_unchanged", n_dones - d0, 1);
    wait_idle("spur", 5000);
    check("spur_frames_final", frames_captured, 2);
    check("spur_error_sticky", error, 1);

    // start+stop together in IDLE: stop wins, error stays
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0; tick(2);
    check("startstop_busy", busy, 0);
    check("startstop_error_kept", error, 1);

    // A real start clears error; then release with empty ring sets it
    pulse_start(1, 0);
    check("start_clears_error", error, 0);
    wait_idle("clr", 500);
    pulse_rel(); tick(1);
    check("underflow_error", error, 1);
    check("underflow_buf_full", buf_full, 0);

`ifdef CAMERA_FRAME_TIMEOUT_EN
    begin
      int k = 0;
      cam_en = 1'b0; r0 = n_rises;
      pulse_start(1, 0);
      wait_rises("to", r0 + 1, 100);
      while (!timeout && k < 300) begin tick(1); k++; end
      check("to_pulse_seen", timeout, 1);
      check("to_pulse_cycle", cyc, rise_cyc + 115);
      cam_en = 1'b1;
      wait_idle("to", 1000);
      check("to_retry_triggers", n_rises - r0, 2);
      check("to_frames", frames_captured, 1);
      check("to_error", error, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
